sram_like_arbiter: RTL and testbench

//  Shares one SRAM-like bus (req/addr_ok/data_ok) between the IF-stage instruction port and the
//  EX/MEM data port, so that MEM_stage load/store traffic and fetch traffic use one memory bridge.
//  It arbitrates address phases, locks a grant until the address is accepted, and records the

---
 rtl/sram_like_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like bus between the fetch and data ports.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed data > inst.
module sram_like_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_OUTS = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [1:0]          bus_size,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                proto_err
);
    localparam int PW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int CW = $clog2(MAX_OUTS + 1);
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [MAX_OUTS-1:0] ids_q, ids_d;
    logic                proto_err_q, proto_err_d;
    logic                winner, grant, push, pop, head_id;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTS - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef SRAM_ARB_RR_EN
    // prio_q names the source that wins a tie; it moves to the other side
    // after every accepted address phase.
    logic prio_q, prio_d;

    always_comb begin
        if (data_req && inst_req) begin
            winner = prio_q;
        end else begin
            winner = data_req ? SRC_DATA : SRC_INST;
        end
    end

    assign prio_d = push ? ~grant : prio_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio_q <= SRC_INST;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign winner = data_req ? SRC_DATA : SRC_INST;
`endif

    assign grant   = (state_q == LOCKED) ? owner_q : winner;
    assign bus_req = resetn & (data_req | inst_req) & (count_q < CW'(MAX_OUTS));
    assign push    = bus_req & bus_addr_ok;
    assign pop     = bus_data_ok & (count_q != '0);
    assign head_id = ids_q[rd_ptr_q];

    always_comb begin
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        if (bus_req) begin
            if (grant == SRC_DATA) begin
                bus_wr    = data_wr;
                bus_size  = data_size;
                bus_wstrb = data_wstrb;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
            end else begin
                bus_size  = 2'd2;
                bus_addr  = inst_addr;
            end
        end
    end

    assign inst_addr_ok = push & (grant == SRC_INST);
    assign data_addr_ok = push & (grant == SRC_DATA);
    assign inst_data_ok = pop & (head_id == SRC_INST);
    assign data_data_ok = pop & (head_id == SRC_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;
    assign proto_err    = proto_err_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ids_d       = ids_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        proto_err_d = proto_err_q | (bus_data_ok & (count_q == '0));
        unique case (state_q)
            IDLE: begin
                if (bus_req && !bus_addr_ok) begin
                    state_d = LOCKED;
                    owner_d = winner;
                end
            end
            LOCKED: begin
                if (push) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            ids_d[wr_ptr_q] = grant;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            owner_q     <= SRC_INST;
            ids_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ids_q       <= ids_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed corner cases plus a randomized
// scoreboard run for sram_like_arbiter.
`timescale 1ns/1ps
module tb_sram_like_arbiter;
    localparam int MO = 2;
`ifdef SRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, data_req = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = '0;
    logic [3:0]  data_wstrb = '0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        proto_err;

    always #5 clk = ~clk;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTS(MO)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .proto_err(proto_err)
    );

    typedef struct {
        bit        breq;
        bit        acc;
        bit        src;
        bit [31:0] addr;
        bit        wr;
        bit [1:0]  size;
        bit [3:0]  wstrb;
        bit [31:0] wdata;
        bit        dok;
    } cyc_t;

    typedef struct {
        bit        src;
        bit [31:0] rdata;
    } rsp_t;

    cyc_t cyc_q[$];
    rsp_t rsp_q[$];
    bit   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   pend_v = 0, pend_src = 0, prio = 0;
    bit   drop_i = 0, drop_d = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: address-side expectations per cycle, responses in order.
    always @(negedge clk) begin
        cyc_t c;
        rsp_t r;
        if (cyc_q.size() > 0) begin
            c = cyc_q.pop_front();
            chk("bus_req", bus_req, c.breq);
            chk("inst_addr_ok", inst_addr_ok, c.acc && !c.src);
            chk("data_addr_ok", data_addr_ok, c.acc && c.src);
            chk("bus_addr", bus_addr, c.breq ? c.addr : 32'h0);
            chk("bus_wr", bus_wr, c.breq ? c.wr : 1'b0);
            chk("bus_size", bus_size, c.breq ? c.size : 2'd0);
            chk("bus_wstrb", bus_wstrb, c.breq ? c.wstrb : 4'h0);
            chk("bus_wdata", bus_wdata, c.breq ? c.wdata : 32'h0);
            if (inst_data_ok || data_data_ok) begin
                if (rsp_q.size() == 0) begin
                    chk("spurious_data_ok", 1, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("data_ok_port", {inst_data_ok, data_data_ok},
                        r.src ? 2'b01 : 2'b10);
                    chk("inst_rdata", inst_rdata, r.src ? 32'h0 : r.rdata);
                    chk("data_rdata", data_rdata, r.src ? r.rdata : 32'h0);
                end
            end else if (c.dok) begin
                chk("missing_data_ok", 0, 1);
            end
        end
    end

    task automatic rand_cycle(input bit allow_new);
        cyc_t c;
        rsp_t r;
        bit   win;
        int   outs;
        @(posedge clk);
        #1;
        if (drop_i) inst_req = 1'b0;
        if (drop_d) data_req = 1'b0;
        drop_i = 0;
        drop_d = 0;
        outs = acc_q.size();
        if (!inst_req && allow_new && $urandom_range(1, 0) == 1) begin
            inst_req  = 1'b1;
            inst_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!data_req && allow_new && $urandom_range(1, 0) == 1) begin
            data_req   = 1'b1;
            data_wr    = 1'($urandom);
            data_size  = 2'($urandom_range(2, 0));
            data_wstrb = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        bus_addr_ok = ($urandom_range(9, 0) < 6);
        bus_data_ok = (outs > 0) && ($urandom_range(1, 0) == 1);
        bus_rdata   = $urandom;
        // A presented but unaccepted phase must be re-presented by the same source.
        c.breq = (inst_req || data_req) && (outs < MO);
        if (pend_v) win = pend_src;
        else if (inst_req && data_req) win = RR ? prio : 1'b1;
        else win = data_req;
        c.src   = win;
        c.acc   = c.breq && bus_addr_ok;
        c.addr  = win ? data_addr : inst_addr;
        c.wr    = win ? data_wr : 1'b0;
        c.size  = win ? data_size : 2'd2;
        c.wstrb = win ? data_wstrb : 4'h0;
        c.wdata = win ? data_wdata : 32'h0;
        c.dok   = bus_data_ok;
        cyc_q.push_back(c);
        if (bus_data_ok) begin
            r.src   = acc_q.pop_front();
            r.rdata = bus_rdata;
            rsp_q.push_back(r);
        end
        if (c.acc) begin
            acc_q.push_back(win);
            pend_v = 0;
            prio   = !win;
            if (win) drop_d = 1;
            else drop_i = 1;
        end else if (c.breq) begin
            pend_v   = 1;
            pend_src = win;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit first;
        // Reset with every input active: outputs must stay quiet.
        inst_req    = 1'b1;
        data_req    = 1'b1;
        inst_addr   = 32'h1c00_0000;
        data_addr   = 32'h1c00_0100;
        bus_addr_ok = 1'b1;
        bus_data_ok = 1'b1;
        #2;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_data_oks", {inst_data_ok, data_data_ok}, 2'b00);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_proto_err", proto_err, 0);

        // Simultaneous requests, then full FIFO, pop+push, in-order returns.
        step();
        resetn      = 1'b1;
        bus_data_ok = 1'b0;
        @(negedge clk);
        first = RR ? 1'b0 : 1'b1;
        chk("tie_data_addr_ok", data_addr_ok, first);
        chk("tie_inst_addr_ok", inst_addr_ok, !first);
        step();
        if (first) data_req = 1'b0;
        else inst_req = 1'b0;
        @(negedge clk);
        chk("second_addr_ok", {inst_addr_ok, data_addr_ok},
            first ? 2'b10 : 2'b01);
        step();
        inst_req   = 1'b0;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_wstrb = 4'b0011;
        data_addr  = 32'h0000_0008;
        data_wdata = 32'h0000_BEEF;
        @(negedge clk);
        chk("full_bus_req", bus_req, 0);
        chk("full_addr_ok", data_addr_ok, 0);
        step();
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hAAAA_5555;
        @(negedge clk);
        chk("nobypass_bus_req", bus_req, 0);
        chk("resp1_port", {inst_data_ok, data_data_ok},
            first ? 2'b01 : 2'b10);
        chk("resp1_rdata", first ? data_rdata : inst_rdata, 32'hAAAA_5555);
        step();
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("store_addr_ok", data_addr_ok, 1);
        chk("store_bus_wr", bus_wr, 1);
        chk("store_bus_wstrb", bus_wstrb, 4'b0011);
        chk("store_bus_wdata", bus_wdata, 32'h0000_BEEF);
        chk("store_bus_addr", bus_addr, 32'h8);
        step();
        data_req    = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1234_5678;
        @(negedge clk);
        chk("resp2_port", {inst_data_ok, data_data_ok},
            first ? 2'b10 : 2'b01);
        chk("resp2_rdata", first ? inst_rdata : data_rdata, 32'h1234_5678);
        step();
        bus_rdata = 32'h0;
        @(negedge clk);
        chk("store_done", data_data_ok, 1);
        chk("no_proto_err", proto_err, 0);

        // Randomized scoreboard run from a fresh reset.
        step();
        bus_data_ok = 1'b0;
        bus_addr_ok = 1'b0;
        resetn      = 1'b0;
        step();
        resetn = 1'b1;
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        for (int i = 0; i < 300; i++) rand_cycle(1'b0);
        chk("drain_outstanding", acc_q.size(), 0);
        step();
        inst_req    = 1'b0;
        data_req    = 1'b0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("drain_responses", rsp_q.size(), 0);
        chk("rand_proto_err", proto_err, 0);

        // Reset while locked with one outstanding, then a stray response.
        step();
        inst_req    = 1'b1;
        inst_addr   = 32'h40;
        bus_addr_ok = 1'b1;
        step();
        inst_req    = 1'b0;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        bus_addr_ok = 1'b0;
        step();
        resetn = 1'b0;
        #1;
        chk("midrst_bus_req", bus_req, 0);
        chk("midrst_bus_addr", bus_addr, 0);
        chk("midrst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        step();
        resetn      = 1'b1;
        data_req    = 1'b0;
        bus_data_ok = 1'b1;
        @(negedge clk);
        chk("stray_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        step();
        bus_data_ok = 1'b0;
        @(negedge clk);
        chk("proto_err_set", proto_err, 1);
        step();
        @(negedge clk);
        chk("proto_err_sticky", proto_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
